// File: rtl/audio_interp_feeder.sv
// Audio sample feeder: small input FIFO plus a linear interpolator that ramps
// between consecutive samples over 2^S output ticks and drives an offset-binary DAC.
module audio_interp_feeder #(
    parameter int unsigned W     = 16,
    parameter int unsigned S     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] in_sample,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         tick,
    output logic [W-1:0] dac_out,
    output logic         underrun,
    input  logic         clr_underrun
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned ACCW = W + S + 1;
    localparam int unsigned DW   = W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic [W-1:0]    r_cur;
    logic [W-1:0]    r_nxt;
    logic [DW-1:0]   r_delta;
    logic [ACCW-1:0] r_acc;
    logic [S-1:0]    r_k;
    logic            r_underrun;
    logic [W-1:0]    r_dac;

    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_hold_entry;
    logic [W-1:0]    w_head;
    logic [W-1:0]    w_base;
    logic [W-1:0]    w_cur_nxt;
    logic [W-1:0]    w_nxt_nxt;
    logic [DW-1:0]   w_delta_nxt;
    logic [ACCW-1:0] w_acc_nxt;
    logic [S-1:0]    w_k_nxt;
    logic [W-1:0]    w_v;

    assign in_ready = (r_count < CW'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_empty  = (r_count == CW'(0));
    assign w_head   = r_mem[r_rd_ptr];
    assign dac_out  = r_dac;
    assign underrun = r_underrun;

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and interpolator next values; only a tick advances anything
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_hold_entry = 1'b0;
        w_base       = r_cur;
        w_cur_nxt    = r_cur;
        w_nxt_nxt    = r_nxt;
        w_delta_nxt  = r_delta;
        w_acc_nxt    = r_acc;
        w_k_nxt      = r_k;
        if (tick) begin
            case (r_state)
                IDLE, HOLD: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = RAMP;
                    end
                end
                RAMP: begin
                    if (!(&r_k)) begin
                        w_acc_nxt = r_acc + {{S{r_delta[W]}}, r_delta};
                        w_k_nxt   = r_k + S'(1);
                    end else begin
                        w_cur_nxt = r_nxt;
                        w_base    = r_nxt;
                        w_acc_nxt = {r_nxt[W-1], r_nxt, {S{1'b0}}};
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_state_nxt  = HOLD;
                            w_hold_entry = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
        // Loading a new target restarts the segment from the current endpoint
        if (w_pop) begin
            w_nxt_nxt   = w_head;
            w_acc_nxt   = {w_base[W-1], w_base, {S{1'b0}}};
            w_k_nxt     = '0;
            w_delta_nxt = {w_head[W-1], w_head} - {w_base[W-1], w_base};
        end
    end

    assign w_v = w_acc_nxt[S+W-1:S];

    // FIFO storage needs no reset; occupancy lives in pointers and count
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= in_sample;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Interpolator datapath, flag and DAC output
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cur      <= '0;
            r_nxt      <= '0;
            r_delta    <= '0;
            r_acc      <= '0;
            r_k        <= '0;
            r_underrun <= 1'b0;
            r_dac      <= {1'b1, {(W-1){1'b0}}};
        end else begin
            r_cur   <= w_cur_nxt;
            r_nxt   <= w_nxt_nxt;
            r_delta <= w_delta_nxt;
            r_acc   <= w_acc_nxt;
            r_k     <= w_k_nxt;
            if (w_hold_entry)      r_underrun <= 1'b1;
            else if (clr_underrun) r_underrun <= 1'b0;
            if (tick) r_dac <= {~w_v[W-1], w_v[W-2:0]};
        end
    end

endmodule

// File: tb/tb_audio_interp_feeder.sv
// Scoreboard bench for audio_interp_feeder (W=16, S=2, DEPTH=4): each tick queues
// its hand-computed DAC code; a monitor compares dac_out one cycle later.
module tb_audio_interp_feeder;

    localparam int unsigned W     = 16;
    localparam int unsigned S     = 2;
    localparam int unsigned DEPTH = 4;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [W-1:0] in_sample = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         tick = 1'b0;
    logic [W-1:0] dac_out;
    logic         underrun;
    logic         clr_underrun = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q [$];

    audio_interp_feeder #(.W(W), .S(S), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .in_sample    (in_sample),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .tick         (tick),
        .dac_out      (dac_out),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Inputs change at posedge+1; every task returns at posedge+1
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        in_valid  = 1'b1;
        in_sample = d;
        @(posedge CLK); #1;
        in_valid  = 1'b0;
    endtask

    task automatic do_tick(input logic [W-1:0] exp, input logic clr);
        tick         = 1'b1;
        clr_underrun = clr;
        exp_q.push_back(exp);
        @(posedge CLK); #1;
        tick         = 1'b0;
        clr_underrun = 1'b0;
        in_valid     = 1'b0;
    endtask

    task automatic ticks5(input logic [W-1:0] e0, input logic [W-1:0] e1,
                          input logic [W-1:0] e2, input logic [W-1:0] e3,
                          input logic [W-1:0] e4);
        do_tick(e0, 1'b0);
        do_tick(e1, 1'b0);
        do_tick(e2, 1'b0);
        do_tick(e3, 1'b0);
        do_tick(e4, 1'b0);
    endtask

    // Monitor: a tick seen at a rising edge has its output checked at the next falling edge
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge CLK);
            if (tick === 1'b1 && RESET === 1'b0) begin
                @(negedge CLK);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dac_unexpected actual=0x%0h expected=<none queued>", dac_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("dac_out", 32'(dac_out), 32'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        idle(2);
        chk("rst_dac", 32'(dac_out), 32'h8000);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_underrun", 32'(underrun), 32'h0);
        RESET = 1'b0;
        idle(1);

        // Tick with empty FIFO in IDLE holds midscale and never flags underrun
        do_tick(16'h8000, 1'b0);
        idle(1);
        chk("idle_no_underrun", 32'(underrun), 32'h0);

        // Ramp 0 -> 0x1000, with a pause proving no-tick cycles hold the output
        push(16'h1000);
        do_tick(16'h8000, 1'b0);
        do_tick(16'h8400, 1'b0);
        idle(3);
        chk("hold_no_tick", 32'(dac_out), 32'h8400);
        do_tick(16'h8800, 1'b0);
        do_tick(16'h8C00, 1'b0);
        do_tick(16'h9000, 1'b0);
        chk("underrun_set", 32'(underrun), 32'h1);

        clr_underrun = 1'b1;
        idle(1);
        clr_underrun = 1'b0;
        chk("underrun_clr", 32'(underrun), 32'h0);

        // Downward ramp 0x1000 -> 0xF000
        push(16'hF000);
        ticks5(16'h9000, 16'h8800, 16'h8000, 16'h7800, 16'h7000);
        chk("underrun_set2", 32'(underrun), 32'h1);
        do_tick(16'h7000, 1'b0);

        // 0xF000 -> 0x7FFF, then full-scale swing 0x7FFF -> 0x8000 (cur + floor(d*k/4))
        push(16'h7FFF);
        ticks5(16'h7000, 16'h93FF, 16'hB7FF, 16'hDBFF, 16'hFFFF);
        push(16'h8000);
        ticks5(16'hFFFF, 16'hBFFF, 16'h7FFF, 16'h3FFF, 16'h0000);

        // Two queued samples: seamless segments, then clear coinciding with HOLD entry
        clr_underrun = 1'b1;
        idle(1);
        clr_underrun = 1'b0;
        push(16'h0000);
        push(16'h0400);
        ticks5(16'h0000, 16'h2000, 16'h4000, 16'h6000, 16'h8000);
        chk("seamless_no_underrun", 32'(underrun), 32'h0);
        do_tick(16'h8100, 1'b0);
        do_tick(16'h8200, 1'b0);
        do_tick(16'h8300, 1'b0);
        do_tick(16'h8400, 1'b1);
        chk("set_beats_clear", 32'(underrun), 32'h1);

        // Fill the FIFO: the 5th sample is held off until space frees
        push(16'h0800);
        chk("ready_after_1", 32'(in_ready), 32'h1);
        push(16'h0C00);
        push(16'h1000);
        chk("ready_after_3", 32'(in_ready), 32'h1);
        push(16'h1400);
        chk("ready_full", 32'(in_ready), 32'h0);
        in_valid  = 1'b1;
        in_sample = 16'h1800;
        idle(2);
        chk("held_off", 32'(in_ready), 32'h0);
        do_tick(16'h8400, 1'b1);
        chk("pop_no_writethrough", 32'(in_ready), 32'h1);
        do_tick(16'h8500, 1'b0);
        do_tick(16'h8600, 1'b0);
        do_tick(16'h8700, 1'b0);
        in_valid  = 1'b1;
        in_sample = 16'h1800;
        do_tick(16'h8800, 1'b0);
        chk("push_pop_same_cycle", 32'(in_ready), 32'h1);
        push(16'h1C00);
        chk("full_again", 32'(in_ready), 32'h0);
        for (int n = 6; n <= 24; n++) begin
            do_tick(16'(32'h8400 + (n - 1) * 32'h100), 1'b0);
        end
        chk("stream_no_underrun", 32'(underrun), 32'h0);
        do_tick(16'h9C00, 1'b0);
        chk("stream_end_underrun", 32'(underrun), 32'h1);

        // Reset in mid-ramp with data queued
        push(16'h2000);
        push(16'h3000);
        push(16'h4000);
        push(16'h5000);
        do_tick(16'h9C00, 1'b0);
        do_tick(16'h9D00, 1'b0);
        push(16'h6000);
        chk("prereset_full", 32'(in_ready), 32'h0);
        idle(1);
        RESET = 1'b1;
        #1;
        chk("async_rst_dac", 32'(dac_out), 32'h8000);
        chk("async_rst_ready", 32'(in_ready), 32'h1);
        chk("async_rst_underrun", 32'(underrun), 32'h0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        idle(1);

        // FIFO contents were discarded; the next sample ramps from 0
        do_tick(16'h8000, 1'b0);
        push(16'h1000);
        ticks5(16'h8000, 16'h8400, 16'h8800, 16'h8C00, 16'h9000);

        idle(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
